// File: rtl/irq_controller_pkg.sv
// Shared register map, default window base and CLAIM layout for the interrupt controller.
// Pure declarations: no latency or flow control.
package irq_controller_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h0000_7F20;

  localparam logic [4:0] OFF_PEND     = 5'h00;
  localparam logic [4:0] OFF_MASK     = 5'h04;
  localparam logic [4:0] OFF_EDGE     = 5'h08;
  localparam logic [4:0] OFF_CLAIM    = 5'h0C;
  localparam logic [4:0] OFF_INSVC    = 5'h10;
  localparam logic [4:0] OFF_COMPLETE = 5'h14;

  localparam int CLAIM_VLD_BIT = 31;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU data-bus slice seen by the interrupt controller.
// Combinational read path; writes take effect at the next clk edge, never stalled.
interface irq_controller_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] rdata;
  logic        hit;

  modport master (output m_data_addr, m_data_wdata, m_data_byteen, input rdata, hit);
  modport slave  (input m_data_addr, m_data_wdata, m_data_byteen, output rdata, hit);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: {vld, id} of the first set request bit.
// Combinational, zero latency; id reads 0 when nothing is requested.
module irq_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic             vld,
  output logic [4:0]       id
);

  always_comb begin
    vld = 1'b0;
    id  = 5'd0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        id  = 5'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latch, mask, priority-encode, claim/complete.
// Edge to interrupt = 2 cycles; register reads combinational, writes always accepted.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          N_SRC = 8,
  parameter logic [31:0] BASE  = DEFAULT_BASE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  irq_controller_if.slave  bus,
  output logic             interrupt
);

  logic [N_SRC-1:0] pend, mask, edge_sel, insvc, irq_prev;
  logic [N_SRC-1:0] active, claim_oh, cmpl_oh, wr_bits, wr_data;
  logic [31:0]      bm;
  logic [4:0]       off, cl_id;
  logic             cl_vld, wr_en, claim_wr, cmpl_wr;
  logic             unused_ok;

  assign off     = {bus.m_data_addr[4:2], 2'b00};
  assign bus.hit = (bus.m_data_addr[31:5] == BASE[31:5]);
  assign wr_en   = bus.hit && (bus.m_data_byteen != 4'b0000);
  assign active  = pend & mask & ~insvc;
  assign bm      = byte_mask(bus.m_data_byteen);
  assign wr_bits = bm[N_SRC-1:0];
  assign wr_data = bus.m_data_wdata[N_SRC-1:0];

  assign unused_ok = ^{bus.m_data_addr[1:0], bus.m_data_wdata, bm};

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req (active),
    .vld (cl_vld),
    .id  (cl_id)
  );

  assign claim_wr = wr_en && (off == OFF_CLAIM) && cl_vld;
  assign cmpl_wr  = wr_en && (off == OFF_COMPLETE);

  // Out-of-range COMPLETE ids match no bit and fall away naturally.
  always_comb begin
    claim_oh = '0;
    cmpl_oh  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      claim_oh[i] = claim_wr && (cl_id == 5'(i));
      cmpl_oh[i]  = cmpl_wr && (bus.m_data_wdata[4:0] == 5'(i));
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.hit) begin
      case (off)
        OFF_PEND:  bus.rdata = 32'(pend);
        OFF_MASK:  bus.rdata = 32'(mask);
        OFF_EDGE:  bus.rdata = 32'(edge_sel);
        OFF_INSVC: bus.rdata = 32'(insvc);
        OFF_CLAIM: begin
          bus.rdata[CLAIM_VLD_BIT] = cl_vld;
          bus.rdata[4:0]           = cl_id;
        end
        default:   bus.rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      mask      <= '0;
      edge_sel  <= '0;
      insvc     <= '0;
      irq_prev  <= '0;
      interrupt <= 1'b0;
    end else begin
      irq_prev  <= irq_in;
      // A fresh edge overrides a claim clear landing on the same bit.
      pend      <= (edge_sel & ((pend & ~claim_oh) | (irq_in & ~irq_prev)))
                 | (~edge_sel & irq_in);
      insvc     <= (insvc | claim_oh) & ~cmpl_oh;
      interrupt <= |active;
      if (wr_en && (off == OFF_MASK))
        mask <= (mask & ~wr_bits) | (wr_data & wr_bits);
      if (wr_en && (off == OFF_EDGE))
        edge_sel <= (edge_sel & ~wr_bits) | (wr_data & wr_bits);
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a per-source behavioural model checked every cycle.
module tb_irq_controller;

  localparam int          N = 8;
  localparam logic [31:0] B = 32'h0000_7F20;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_in;
  logic         interrupt;

  irq_controller_if bus ();

  irq_controller #(.N_SRC(N), .BASE(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .bus       (bus),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: one flag per source for each architectural property.
  bit m_pend [N];
  bit m_mask [N];
  bit m_edge [N];
  bit m_insvc[N];
  bit m_prev [N];
  bit m_int;
  int m_cid;
  bit m_w;
  int m_wi;

  function automatic int first_active();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_mask[i] && !m_insvc[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] r;
    int c;
    r = '0;
    if (a[31:5] != B[31:5]) return '0;
    case (int'(a[4:2]))
      0: for (int i = 0; i < N; i++) r[i] = m_pend[i];
      1: for (int i = 0; i < N; i++) r[i] = m_mask[i];
      2: for (int i = 0; i < N; i++) r[i] = m_edge[i];
      3: begin
        c = first_active();
        if (c >= 0) r = 32'h8000_0000 + 32'(c);
      end
      4: for (int i = 0; i < N; i++) r[i] = m_insvc[i];
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_mask[i] = 0; m_edge[i] = 0; m_insvc[i] = 0; m_prev[i] = 0;
      end
      m_int = 0;
    end else begin
      m_cid = first_active();
      m_w   = (bus.m_data_addr[31:5] == B[31:5]) && (bus.m_data_byteen != 4'b0);
      m_wi  = int'(bus.m_data_addr[4:2]);
      m_int = (m_cid >= 0);
      for (int i = 0; i < N; i++) begin
        if (m_edge[i]) begin
          if (m_w && m_wi == 3 && m_cid == i) m_pend[i] = 0;
          if (irq_in[i] && !m_prev[i]) m_pend[i] = 1;
        end else begin
          m_pend[i] = irq_in[i];
        end
      end
      if (m_w && m_wi == 3 && m_cid >= 0) m_insvc[m_cid] = 1;
      if (m_w && m_wi == 5 && int'(bus.m_data_wdata[4:0]) < N)
        m_insvc[int'(bus.m_data_wdata[4:0])] = 0;
      for (int i = 0; i < N; i++) begin
        if (m_w && bus.m_data_byteen[i / 8]) begin
          if (m_wi == 1) m_mask[i] = bus.m_data_wdata[i];
          if (m_wi == 2) m_edge[i] = bus.m_data_wdata[i];
        end
        m_prev[i] = irq_in[i];
      end
    end
  end

  task automatic ck(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ck("hit", 32'(bus.hit), 32'(bus.m_data_addr[31:5] == B[31:5]));
      ck("rdata", bus.rdata, exp_rdata(bus.m_data_addr));
      ck("interrupt", 32'(interrupt), 32'(m_int));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
    bus.m_data_addr   = B + off;
    bus.m_data_wdata  = data;
    bus.m_data_byteen = be;
    tick();
    bus.m_data_byteen = 4'b0;
    bus.m_data_wdata  = '0;
    bus.m_data_addr   = '0;
  endtask

  task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp);
    bus.m_data_addr   = B + off;
    bus.m_data_byteen = 4'b0;
    #1;
    ck(name, bus.rdata, exp);
  endtask

  initial begin
    reset = 1'b1;
    irq_in = '0;
    bus.m_data_addr = '0;
    bus.m_data_wdata = '0;
    bus.m_data_byteen = 4'b0;
    tick();
    tick();
    chk_en = 1'b1;
    reset = 1'b0;
    rd("rst_pend", 32'h00, 32'h0);
    rd("rst_mask", 32'h04, 32'h0);
    rd("rst_claim", 32'h0C, 32'h0);
    ck("rst_int", 32'(interrupt), 32'h0);

    // 1: edge source 0 through claim
    wr(32'h04, 32'h0000_0005, 4'hF);
    wr(32'h08, 32'h0000_0001, 4'hF);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    ck("t1_int_lat1", 32'(interrupt), 32'h0);
    tick();
    rd("t1_pend", 32'h00, 32'h1);
    ck("t1_int_lat2", 32'(interrupt), 32'h1);
    rd("t1_claim", 32'h0C, 32'h8000_0000);
    wr(32'h0C, 32'hDEAD_BEEF, 4'hF);
    tick();
    ck("t1_int_drop", 32'(interrupt), 32'h0);
    rd("t1_insvc", 32'h10, 32'h1);
    rd("t1_pend_clr", 32'h00, 32'h0);

    // 2: level source 2 alongside edge source 0, nested claims
    wr(32'h14, 32'h0, 4'hF);
    irq_in = 8'h05;
    tick();
    irq_in = 8'h04;
    tick();
    rd("t2_claim0", 32'h0C, 32'h8000_0000);
    wr(32'h0C, 32'h0, 4'hF);
    rd("t2_claim2", 32'h0C, 32'h8000_0002);
    wr(32'h0C, 32'h0, 4'hF);
    tick();
    tick();
    ck("t2_int_blocked", 32'(interrupt), 32'h0);
    rd("t2_insvc", 32'h10, 32'h5);
    rd("t2_pend_lvl", 32'h00, 32'h4);
    wr(32'h14, 32'h2, 4'hF);
    tick();
    ck("t2_int_refire", 32'(interrupt), 32'h1);
    irq_in = 8'h00;
    tick();
    wr(32'h14, 32'h0, 4'hF);
    tick();
    ck("t2_int_idle", 32'(interrupt), 32'h0);
    rd("t2_insvc_clr", 32'h10, 32'h0);

    // 3: masked level source fires once unmasked
    irq_in = 8'h02;
    tick();
    tick();
    rd("t3_pend", 32'h00, 32'h2);
    ck("t3_int_masked", 32'(interrupt), 32'h0);
    wr(32'h04, 32'h2, 4'hF);
    tick();
    ck("t3_int_unmask", 32'(interrupt), 32'h1);
    irq_in = 8'h00;
    tick();
    tick();

    // 4: claim and new edge on the same bit in the same cycle
    wr(32'h04, 32'h1, 4'hF);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    irq_in = 8'h01;
    wr(32'h0C, 32'h0, 4'hF);
    irq_in = 8'h00;
    rd("t4_pend_set_wins", 32'h00, 32'h1);
    rd("t4_insvc", 32'h10, 32'h1);
    wr(32'h14, 32'h8, 4'hF);
    rd("t4_cmpl_oob", 32'h10, 32'h1);
    rd("t4_alias_mask", 32'h06, 32'h1);

    // 5: byte enables and out-of-window accesses
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h04, 32'hFFFF_FFFF, 4'b0010);
    rd("t5_mask_b1", 32'h04, 32'h0);
    wr(32'h04, 32'hFFFF_FFA5, 4'b0001);
    rd("t5_mask_b0", 32'h04, 32'hA5);
    bus.m_data_addr   = 32'h0000_7F40;
    bus.m_data_wdata  = 32'hFFFF_FFFF;
    bus.m_data_byteen = 4'hF;
    #1;
    ck("t5_miss_hit", 32'(bus.hit), 32'h0);
    ck("t5_miss_rdata", bus.rdata, 32'h0);
    tick();
    bus.m_data_byteen = 4'b0;
    wr(32'h24, 32'h0, 4'hF);
    rd("t5_mask_kept", 32'h04, 32'hA5);
    rd("t5_edge_kept", 32'h08, 32'h1);

    // 6: reset in mid-operation
    irq_in = 8'h04;
    tick();
    tick();
    ck("t6_int_pre", 32'(interrupt), 32'h1);
    reset  = 1'b1;
    irq_in = 8'h00;
    tick();
    reset = 1'b0;
    ck("t6_int_rst", 32'(interrupt), 32'h0);
    rd("t6_pend", 32'h00, 32'h0);
    rd("t6_insvc", 32'h10, 32'h0);
    tick();
    rd("t6_mask", 32'h04, 32'h0);
    rd("t6_edge", 32'h08, 32'h0);
    rd("t6_claim", 32'h0C, 32'h0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
